// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequential front-end for a combinational W-bit ALU. Commands are queued
//   in a small FIFO. One command per cycle is issued from the FIFO head into
//   the ALU. The ALU result and flags are registered into a valid/ready result
//   port. An accumulator holds the last issued result, so that commands with
//   use_acc = 1 can chain on it without external feedback.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   clear                 : synchronous flush of FIFO, result register, accumulator
//   cmd_valid/cmd_ready   : command handshake; cmd_op/use_acc/a/b carry the command
//   alu_a/alu_b/alu_op    : drive to the external ALU (combinational from FIFO head)
//   alu_out/zero/carry/ovf: result and flags returned by the ALU
//   res_valid/res_ready   : result handshake; res_data/zero/carry/ovf are registered
//   ops_done              : issued-operation counter, wraps modulo 2^CNT_W
//   busy                  : FIFO non-empty or an unconsumed result is held
module alu_issue_ctrl #(
  parameter int W     = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_use_acc,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_zero,
  output logic             res_carry,
  output logic             res_ovf,
  output logic [CNT_W-1:0] ops_done,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Entry layout: {op[2:0], use_acc, a[W-1:0], b[W-1:0]}
  localparam int EW = 4 + 2 * W;

  logic [EW-1:0]    entry_q [DEPTH];
  logic [EW-1:0]    entry_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_carry_q, res_carry_d;
  logic             res_ovf_q, res_ovf_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic             full, empty, push, issue;
  logic [EW-1:0]    cmd_word, head;
  logic [2:0]       head_op;
  logic             head_use_acc;
  logic [W-1:0]     head_a, head_b;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // cmd_ready looks only at full, so a pop in the same cycle does not free a slot early.
  assign cmd_ready = !full && !clear;
  assign push      = cmd_valid && cmd_ready;
  assign issue     = !empty && (!res_valid_q || res_ready) && !clear;

  assign cmd_word     = {cmd_op, cmd_use_acc, cmd_a, cmd_b};
  assign head         = entry_q[rd_ptr_q[AW-1:0]];
  assign head_op      = head[EW-1 -: 3];
  assign head_use_acc = head[2*W];
  assign head_a       = head[2*W-1 -: W];
  assign head_b       = head[W-1:0];

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (!empty) begin
      alu_op = head_op;
      alu_b  = head_b;
      alu_a  = head_use_acc ? acc_q : head_a;
    end
  end

  // FIFO storage, one register per entry
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_d[gi] = (push && (wr_ptr_q[AW-1:0] == AW'(gi))) ? cmd_word : entry_q[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_q[gi] <= '0;
        end else begin
          entry_q[gi] <= entry_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
    res_ovf_d   = res_ovf_q;
    acc_d       = acc_q;
    ops_done_d  = ops_done_q;
    if (clear) begin
      // Flush everything except the operation counter.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      res_valid_d = 1'b0;
      res_data_d  = '0;
      res_zero_d  = 1'b0;
      res_carry_d = 1'b0;
      res_ovf_d   = 1'b0;
      acc_d       = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (issue) begin
        rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
        res_valid_d = 1'b1;
        res_data_d  = alu_out;
        res_zero_d  = alu_zero;
        res_carry_d = alu_carry;
        res_ovf_d   = alu_ovf;
        acc_d       = alu_out;
        ops_done_d  = ops_done_q + CNT_W'(1);
      end else if (res_valid_q && res_ready) begin
        res_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      acc_q       <= '0;
      ops_done_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
      res_ovf_q   <= res_ovf_d;
      acc_q       <= acc_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_carry = res_carry_q;
  assign res_ovf   = res_ovf_q;
  assign ops_done  = ops_done_q;
  assign busy      = !empty || res_valid_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Bench for alu_issue_ctrl. A behavioural 4-bit ALU is attached to the alu_*
//   ports. A transaction-level reference model follows the design: a queue of
//   pending commands, each with its precomputed effective operands and result,
//   plus one result slot. The model is checked every cycle against the design.
//   Directed scenarios come first, followed by a randomized phase.
module tb_alu_issue_ctrl;
  localparam int W     = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic             cmd_use_acc;
  logic [W-1:0]     cmd_a, cmd_b;
  logic [W-1:0]     alu_a, alu_b;
  logic [2:0]       alu_op;
  logic [W-1:0]     alu_out;
  logic             alu_zero, alu_carry, alu_ovf;
  logic             res_valid, res_ready;
  logic [W-1:0]     res_data;
  logic             res_zero, res_carry, res_ovf;
  logic [CNT_W-1:0] ops_done;
  logic             busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_use_acc(cmd_use_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_carry(res_carry), .res_ovf(res_ovf),
    .ops_done(ops_done), .busy(busy)
  );

  // Behavioural ALU: returns {zero, carry, ovf, out}
  function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] o;
    logic       c, v;
    s = '0; o = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b};         o = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (o[3] != a[3]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; o = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (o[3] != a[3]); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: o = ~a;
      3'd6: o = {a[2:0], 1'b0};
      default: o = b;
    endcase
    return {(o == 4'd0), c, v, o};
  endfunction

  always_comb {alu_zero, alu_carry, alu_ovf, alu_out} = alu_f(alu_op, alu_a, alu_b);

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [6:0] r;
  } item_t;

  item_t      mq[$];
  logic       slot_v;
  logic [6:0] slot_r;
  logic [3:0] m_acc;
  int         m_cnt;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    slot_v = 1'b0;
    slot_r = '0;
    m_acc  = '0;
    m_cnt  = 0;
  endtask

  task automatic set_cmd(input logic v, input logic [2:0] op, input logic ua, input logic [3:0] a, input logic [3:0] b);
    cmd_valid   = v;
    cmd_op      = op;
    cmd_use_acc = ua;
    cmd_a       = a;
    cmd_b       = b;
  endtask

  // Called just after a falling edge with the inputs set up. It checks the
  // design against the model, advances the model across the rising edge,
  // and returns on the next falling edge.
  task automatic cycle();
    logic  iss, rdy;
    item_t it;
    #1;
    rdy = (mq.size() < DEPTH) && !clear;
    iss = (mq.size() > 0) && (!slot_v || res_ready) && !clear;
    chk("cmd_ready", cmd_ready, rdy);
    chk("res_valid", res_valid, slot_v);
    chk("busy", busy, (mq.size() > 0) || slot_v);
    chk("ops_done", ops_done, 32'(m_cnt % (1 << CNT_W)));
    if (slot_v) chk("res_bundle", {res_zero, res_carry, res_ovf, res_data}, slot_r);
    if (mq.size() > 0) chk("alu_drive", {alu_op, alu_a, alu_b}, {mq[0].op, mq[0].a, mq[0].b});
    else               chk("alu_idle", {alu_op, alu_a, alu_b}, 0);
    @(posedge clk);
    if (clear) begin
      mq.delete();
      slot_v = 1'b0;
      m_acc  = '0;
    end else begin
      if (slot_v && res_ready) slot_v = 1'b0;
      if (iss) begin
        it     = mq.pop_front();
        slot_v = 1'b1;
        slot_r = it.r;
        m_cnt++;
        $display("issue op=%0d a=%h b=%h -> res=%h flags(z,c,v)=%b", it.op, it.a, it.b, it.r[3:0], it.r[6:4]);
      end
      if (cmd_valid && rdy) begin
        it.op = cmd_op;
        it.a  = cmd_use_acc ? m_acc : cmd_a;
        it.b  = cmd_b;
        it.r  = alu_f(it.op, it.a, it.b);
        m_acc = it.r[3:0];
        mq.push_back(it);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] bop [3];
    logic [3:0] ba  [3];
    logic [3:0] bb  [3];

    rst_n = 1'b0; clear = 1'b0; res_ready = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    model_reset();

    // Reset then idle
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    chk("rst_res", {res_zero, res_carry, res_ovf, res_data}, 0);
    rst_n = 1'b1;

    // Single add: 3 + 5
    res_ready = 1'b1;
    set_cmd(1, 3'd0, 0, 4'd3, 4'd5);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    #1 chk("add_not_yet", res_valid, 0);
    cycle();
    #1;
    chk("add_valid", res_valid, 1);
    chk("add_data", res_data, 8);
    chk("add_flags", {res_zero, res_carry, res_ovf}, 3'b001);
    chk("add_ops", ops_done, 1);

    // Chain: 7+1 then acc-8
    set_cmd(1, 3'd0, 0, 4'd7, 4'd1);
    cycle();
    set_cmd(1, 3'd1, 1, 4'hF, 4'd8);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    #1 chk("chain_alu_a", alu_a, 8);
    cycle();
    #1;
    chk("chain_data", res_data, 0);
    chk("chain_zero", res_zero, 1);
    set_cmd(1, 3'd0, 1, 4'hF, 4'd3);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    cycle();
    #1 chk("chain_acc", res_data, 3);
    cycle();

    // Backpressure
    for (int i = 0; i < 3; i++) begin
      bop[i] = 3'($urandom_range(0, 7));
      ba[i]  = 4'($urandom);
      bb[i]  = 4'($urandom);
    end
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1, bop[i], 0, ba[i], bb[i]);
      cycle();
    end
    set_cmd(0, 0, 0, 0, 0);
    #1;
    chk("bp_full", cmd_ready, 0);
    chk("bp_first", res_data, alu_f(bop[0], ba[0], bb[0]) & 7'h0F);
    cycle();
    #1 chk("bp_hold", res_data, alu_f(bop[0], ba[0], bb[0]) & 7'h0F);
    res_ready = 1'b1;
    set_cmd(1, 3'd0, 0, 4'd1, 4'd1);   // offered while full: must wait a cycle
    cycle();
    #1;
    chk("bp_second", res_data, alu_f(bop[1], ba[1], bb[1]) & 7'h0F);
    chk("bp_ready_back", cmd_ready, 1);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    #1 chk("bp_third", res_data, alu_f(bop[2], ba[2], bb[2]) & 7'h0F);
    cycle();
    #1 chk("bp_late_push", res_data, 2);
    cycle();

    // Clear with pending work
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1, 3'($urandom_range(0, 7)), 0, 4'($urandom), 4'($urandom));
      cycle();
    end
    clear = 1'b1;
    set_cmd(1, 3'd0, 0, 4'd1, 4'd1);
    #1 chk("clr_cmd_ready", cmd_ready, 0);
    cycle();
    clear = 1'b0;
    set_cmd(0, 0, 0, 0, 0);
    #1;
    chk("clr_res_valid", res_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_ops_kept", ops_done, 32'(m_cnt % (1 << CNT_W)));
    chk("clr_alu", {alu_op, alu_a, alu_b}, 0);
    res_ready = 1'b1;
    set_cmd(1, 3'd0, 1, 4'hF, 4'd5);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    cycle();
    #1 chk("clr_acc_zero", res_data, 5);
    cycle();

    // Asynchronous reset mid-stream
    res_ready = 1'b0;
    set_cmd(1, 3'd0, 0, 4'd1, 4'd2);
    cycle();
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    #1 chk("ar_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_res_valid", res_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ops_done", ops_done, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    set_cmd(1, 3'd0, 0, 4'd2, 4'd2);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    cycle();
    #1 chk("ar_after_add", res_data, 4);
    cycle();

    // Randomized phase
    for (int n = 0; n < 700; n++) begin
      set_cmd($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), 4'($urandom));
      res_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 49) == 0);
      cycle();
    end
    clear = 1'b0;
    res_ready = 1'b1;
    set_cmd(0, 0, 0, 0, 0);
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
